eth_rx_pkt_reader: RTL and testbench
====================================

Name: eth_rx_pkt_reader

Overview:
Downstream stage of the GMII receive front end. It drains the per-port receive data FIFO (9-bit words, byte in [7:0]) and command FIFO (72-bit descriptors), one packet per descriptor. Good packets are forwarded byte-by-byte on a valid/ready stream with SOP/EOP markers. Packets flagged CRC-error or delete, and runts and giants, are silently drained from the data FIFO and counted.

Parameters:
MIN_LEN, 60, minimum accepted length in bytes (FCS excluded); shorter packets are dropped as runts.
MAX_LEN, 1514, maximum accepted length in bytes (FCS excluded); longer packets are dropped as giants.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock, 125 MHz
reset  in  1  asynchronous, active-high reset
cmd_fifo_empty  in  1  command FIFO empty (FWFT FIFO: head descriptor valid on cmd_fifo_dout while empty=0)
cmd_fifo_rd  out  1  pop the command FIFO head
cmd_fifo_dout  in  72  descriptor: [53]=crc_err, [52]=delete, [10:0]=byte length; all other bits ignored
data_fifo_empty  in  1  data FIFO empty (FWFT)
data_fifo_rd  out  1  pop the data FIFO head
data_fifo_dout  in  9  data FIFO head; [7:0] carries the byte, [8] is ignored
out_valid  out  1  output byte valid
out_data  out  8  output byte
out_sop  out  1  first byte of packet, qualified by out_valid
out_eop  out  1  last byte of packet, qualified by out_valid
out_ready  in  1  sink accepts the byte when out_valid and out_ready are both 1
pkt_ok_cnt  out  CNT_W  packets forwarded, saturating
pkt_drop_cnt  out  CNT_W  packets dropped, all causes, saturating
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: every output is 0, the FSM is in IDLE and all internal counters are 0.
- FIFO convention: both FIFOs are first-word-fall-through, and a pop takes effect on the clock edge where rd=1.
- Rd safety: cmd_fifo_rd and data_fifo_rd are combinational and must never be asserted while the corresponding empty is 1.
- FSM states: IDLE, LOAD, FWD, DROP.
- IDLE: when cmd_fifo_empty=0, assert cmd_fifo_rd for exactly one cycle, latch len=dout[10:0] and the drop decision, then go to LOAD.
  - drop = crc_err | delete | (len<MIN_LEN) | (len>MAX_LEN).
  - A descriptor with len=0 counts as a drop and causes no data reads.
- LOAD (1 cycle): set remaining=len and first=1. Go to DROP if drop=1, else FWD. If len=0, increment pkt_drop_cnt and return to IDLE.
- FWD:
  - data_fifo_rd = !data_fifo_empty && (!out_valid || out_ready).
  - On a pop, register out_data=dout[7:0], out_valid=1, out_sop=first, out_eop=(remaining==1); clear first and decrement remaining.
  - An accepted output byte with no new pop clears out_valid.
  - When remaining reaches 0 and the last byte is accepted (eop handshake), increment pkt_ok_cnt and go to IDLE.
  - Output registers hold stable while out_valid=1 and out_ready=0.
  - An empty data FIFO mid-packet stalls with no timeout; there is no bubble requirement.
- DROP: data_fifo_rd = !data_fifo_empty. Each pop decrements remaining. At 0, increment pkt_drop_cnt and return to IDLE. The output stream stays idle throughout.
- Throughput: in FWD with out_ready held high and data available, one byte per cycle. Per-packet overhead is 2 cycles (IDLE pop plus LOAD) before the first data pop. out_sop appears 1 cycle after the first pop.
- Counters: saturate at all-ones; they do not wrap.
- Next descriptor: not read before the previous packet's final byte has been popped (DROP) or accepted (FWD).
- Ordering: descriptors are processed in FIFO order, and data bytes are never reordered.
- Reset mid-packet: returns to IDLE immediately and drops out_valid. The FIFOs are reset alongside this block, so no resynchronisation is needed.

Test Plan:
- Descriptor len=64, crc_err=0, delete=0; 64 bytes 0x00..0x3F queued; out_ready=1 -> 64 consecutive valid beats. Sop on 0x00, eop on 0x3F. pkt_ok_cnt=1. cmd_fifo_rd pulses once.
- Descriptor with [53]=1, len=100 -> exactly 100 data pops and no out_valid. pkt_drop_cnt=1. A following good 60-byte packet then forwards intact.
- Descriptors len=59, len=1515 and len=1514 -> the first two are drained (59 and 1515 pops) and pkt_drop_cnt=2. The 1514-byte packet forwards.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly on a 60-byte packet -> out_data stable while stalled, no byte lost or duplicated, and data_fifo_rd=0 whenever out_valid=1 and out_ready=0.
- Data FIFO runs empty after byte 30 of 64 for 10 cycles -> the FSM stays in FWD and resumes. Sop and eop each occur exactly once.
- Assert reset during byte 20 of a forward, then release; issue a fresh descriptor with len=60 -> all outputs 0 during reset, and the new packet forwards correctly with sop on its first byte.

Source files
------------

// File: rtl/eth_rx_pkt_reader.sv
// Receive packet reader: pops one descriptor per packet from the command FIFO and
// either streams the packet's bytes out with SOP/EOP markers or drains them silently.
module eth_rx_pkt_reader #(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_fifo_empty,
   output logic             cmd_fifo_rd,
   input  logic [71:0]      cmd_fifo_dout,
   input  logic             data_fifo_empty,
   output logic             data_fifo_rd,
   input  logic [8:0]       data_fifo_dout,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_sop,
   output logic             out_eop,
   input  logic             out_ready,
   output logic [CNT_W-1:0] pkt_ok_cnt,
   output logic [CNT_W-1:0] pkt_drop_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOAD, FWD, DROP} state_t;

   state_t           state_q;
   logic [10:0]      len_q;
   logic [10:0]      rem_q;
   logic             drop_q;
   logic             first_q;
   logic             out_valid_q;
   logic [7:0]       out_data_q;
   logic             out_sop_q;
   logic             out_eop_q;
   logic [CNT_W-1:0] ok_cnt_q;
   logic [CNT_W-1:0] ok_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q;
   logic [CNT_W-1:0] drop_cnt_d;

   logic [10:0]      cmd_len;
   logic             cmd_drop;
   logic             out_take;
   logic             unused_bits;

   assign cmd_len  = cmd_fifo_dout[10:0];
   assign cmd_drop = cmd_fifo_dout[53] | cmd_fifo_dout[52] |
                     (int'(cmd_len) < MIN_LEN) | (int'(cmd_len) > MAX_LEN);
   assign out_take = out_valid_q & out_ready;

   assign unused_bits = ^{cmd_fifo_dout[71:54], cmd_fifo_dout[51:11], data_fifo_dout[8]};

   assign ok_cnt_d   = (&ok_cnt_q)   ? ok_cnt_q   : ok_cnt_q + 1'b1;
   assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;

   // Pops stop once the packet's bytes are all out of the data FIFO, so a stalled
   // final byte never lets the next packet's data be consumed early.
   always_comb begin
      cmd_fifo_rd  = 1'b0;
      data_fifo_rd = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE:    cmd_fifo_rd  = !cmd_fifo_empty;
            FWD:     data_fifo_rd = !data_fifo_empty && (rem_q != 11'd0) &&
                                    (!out_valid_q || out_ready);
            DROP:    data_fifo_rd = !data_fifo_empty && (rem_q != 11'd0);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         rem_q       <= '0;
         drop_q      <= 1'b0;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         ok_cnt_q    <= '0;
         drop_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_fifo_rd) begin
                  len_q   <= cmd_len;
                  drop_q  <= cmd_drop;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               rem_q   <= len_q;
               first_q <= 1'b1;
               if (len_q == 11'd0) begin
                  drop_cnt_q <= drop_cnt_d;
                  state_q    <= IDLE;
               end else begin
                  state_q <= drop_q ? DROP : FWD;
               end
            end
            FWD: begin
               if (data_fifo_rd) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= data_fifo_dout[7:0];
                  out_sop_q   <= first_q;
                  out_eop_q   <= (rem_q == 11'd1);
                  first_q     <= 1'b0;
                  rem_q       <= rem_q - 11'd1;
               end else if (out_take) begin
                  out_valid_q <= 1'b0;
                  out_sop_q   <= 1'b0;
                  out_eop_q   <= 1'b0;
                  if (out_eop_q) begin
                     ok_cnt_q <= ok_cnt_d;
                     state_q  <= IDLE;
                  end
               end
            end
            DROP: begin
               if (data_fifo_rd) begin
                  rem_q <= rem_q - 11'd1;
                  if (rem_q == 11'd1) begin
                     drop_cnt_q <= drop_cnt_d;
                     state_q    <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_sop      = out_sop_q;
   assign out_eop      = out_eop_q;
   assign pkt_ok_cnt   = ok_cnt_q;
   assign pkt_drop_cnt = drop_cnt_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_eth_rx_pkt_reader.sv
// Bench for eth_rx_pkt_reader: queue-modelled FWFT FIFOs, a byte scoreboard and
// a descriptor table, plus hand sequences for backpressure, underrun, reset and saturation.
`timescale 1ns/1ps
module tb_eth_rx_pkt_reader;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int BUDGET = 6000;

   logic             clk;
   logic             reset;
   logic             cmd_fifo_empty;
   logic             cmd_fifo_rd;
   logic [71:0]      cmd_fifo_dout;
   logic             data_fifo_empty;
   logic             data_fifo_rd;
   logic [8:0]       data_fifo_dout;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_sop;
   logic             out_eop;
   logic             out_ready;
   logic [CNT_W-1:0] pkt_ok_cnt;
   logic [CNT_W-1:0] pkt_drop_cnt;
   logic             busy;

   eth_rx_pkt_reader #(.MIN_LEN(60), .MAX_LEN(1514), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd(cmd_fifo_rd), .cmd_fifo_dout(cmd_fifo_dout),
      .data_fifo_empty(data_fifo_empty), .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_ready(out_ready), .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } exp_t;

   typedef struct {
      int len;
      bit crc;
      bit del;
      bit fwd;
   } vec_t;

   logic [71:0] cq[$];
   logic [8:0]  dq[$];
   exp_t        expq[$];

   int total, bad;
   int cyc, ncmd, ndpop, nvalid, naccept, nsop, neop;
   int viol_rd, viol_bp, viol_hold;
   int cmd_cyc, acc_first, acc_last;
   int rmode;
   int exp_ok, exp_drop;
   bit hold_pend;
   logic [7:0] hd;
   logic hs, he;

   function automatic void check(string nm, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endfunction

   function automatic int sat(int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic void refresh();
      cmd_fifo_empty  = (cq.size() == 0);
      cmd_fifo_dout   = cmd_fifo_empty ? 72'd0 : cq[0];
      data_fifo_empty = (dq.size() == 0);
      data_fifo_dout  = data_fifo_empty ? 9'd0 : dq[0];
   endfunction

   // One clock: sample DUT at the edge (pre-update), then model FIFO pops.
   task automatic tick();
      logic cp, dp, ce, de;
      exp_t e;
      @(posedge clk);
      cp = cmd_fifo_rd; dp = data_fifo_rd; ce = cmd_fifo_empty; de = data_fifo_empty;
      if (!reset) begin
         if ((cp && ce) || (dp && de)) viol_rd++;
         if (hold_pend && !(out_valid && out_data == hd && out_sop == hs && out_eop == he))
            viol_hold++;
         hold_pend = 1'b0;
         if (out_valid) nvalid++;
         if (out_valid && !out_ready) begin
            if (dp) viol_bp++;
            hold_pend = 1'b1; hd = out_data; hs = out_sop; he = out_eop;
         end
         if (out_valid && out_ready) begin
            naccept++;
            if (out_sop) begin nsop++; acc_first = cyc; end
            if (out_eop) begin neop++; acc_last = cyc; end
            if (expq.size() == 0) check("unexpected_byte", 1, 0);
            else begin
               e = expq.pop_front();
               check("byte_data", int'(out_data), int'(e.d));
               check("byte_sop", int'(out_sop), int'(e.sop));
               check("byte_eop", int'(out_eop), int'(e.eop));
            end
         end
         if (cp) begin ncmd++; cmd_cyc = cyc; end
         if (dp) ndpop++;
      end
      #1;
      if (cp && cq.size() > 0) void'(cq.pop_front());
      if (dp && dq.size() > 0) void'(dq.pop_front());
      cyc++;
      out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      refresh();
   endtask

   task automatic push_pkt(input int len, input bit crc, input bit del, input bit fwd, input int seed);
      logic [71:0] d;
      logic [7:0] b;
      exp_t e;
      d[31:0]  = $urandom;
      d[63:32] = $urandom;
      d[71:64] = 8'($urandom);
      d[53] = crc;
      d[52] = del;
      d[10:0] = 11'(len);
      cq.push_back(d);
      for (int i = 0; i < len; i++) begin
         b = 8'(i + seed);
         dq.push_back({1'($urandom), b});
         if (fwd) begin
            e.d = b; e.sop = (i == 0); e.eop = (i == len - 1);
            expq.push_back(e);
         end
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!(cq.size() == 0 && dq.size() == 0 && expq.size() == 0 && !busy) && n < BUDGET) begin
         tick();
         n++;
      end
      check({nm, "_done_in_budget"}, int'(n < BUDGET), 1);
   endtask

   task automatic run_vec(input vec_t v, input int seed, input string nm);
      int c0, p0, v0, a0;
      c0 = ncmd; p0 = ndpop; v0 = nvalid; a0 = naccept;
      push_pkt(v.len, v.crc, v.del, v.fwd, seed);
      refresh();
      wait_done(nm);
      if (v.fwd) exp_ok = sat(exp_ok); else exp_drop = sat(exp_drop);
      check({nm, "_ok_cnt"}, int'(pkt_ok_cnt), exp_ok);
      check({nm, "_drop_cnt"}, int'(pkt_drop_cnt), exp_drop);
      check({nm, "_data_pops"}, ndpop - p0, v.len);
      check({nm, "_cmd_pops"}, ncmd - c0, 1);
      if (!v.fwd) check({nm, "_valid_beats"}, nvalid - v0, 0);
      else begin
         check({nm, "_accepted"}, naccept - a0, v.len);
         if (rmode == 0) begin
            check({nm, "_burst_len"}, acc_last - acc_first, v.len - 1);
            check({nm, "_sop_latency"}, acc_first - cmd_cyc, 3);
         end
      end
   endtask

   vec_t tbl[10];
   logic [8:0] held[$];

   initial begin
      total = 0; bad = 0; cyc = 0; ncmd = 0; ndpop = 0; nvalid = 0; naccept = 0;
      nsop = 0; neop = 0; viol_rd = 0; viol_bp = 0; viol_hold = 0;
      cmd_cyc = 0; acc_first = 0; acc_last = 0; rmode = 0; exp_ok = 0; exp_drop = 0;
      hold_pend = 1'b0; hd = '0; hs = 1'b0; he = 1'b0;
      out_ready = 1'b1;
      reset = 1'b0;
      refresh();
      tbl[0] = '{len: 64,   crc: 0, del: 0, fwd: 1};
      tbl[1] = '{len: 100,  crc: 1, del: 0, fwd: 0};
      tbl[2] = '{len: 60,   crc: 0, del: 0, fwd: 1};
      tbl[3] = '{len: 59,   crc: 0, del: 0, fwd: 0};
      tbl[4] = '{len: 1515, crc: 0, del: 0, fwd: 0};
      tbl[5] = '{len: 1514, crc: 0, del: 0, fwd: 1};
      tbl[6] = '{len: 80,   crc: 0, del: 1, fwd: 0};
      tbl[7] = '{len: 0,    crc: 0, del: 0, fwd: 0};
      tbl[8] = '{len: 200,  crc: 1, del: 1, fwd: 0};
      tbl[9] = '{len: 1,    crc: 0, del: 0, fwd: 0};

      #1 reset = 1'b1;
      #2;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_sop_eop", int'({out_sop, out_eop}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_counts", int'({pkt_ok_cnt, pkt_drop_cnt}), 0);
      check("rst_rd", int'({cmd_fifo_rd, data_fifo_rd}), 0);
      repeat (3) tick();
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(tbl[i], i * 17, $sformatf("vec%0d", i));

      // Backpressure 1,0,0,1 on a 60-byte packet.
      rmode = 1;
      run_vec('{len: 60, crc: 0, del: 0, fwd: 1}, 5, "bp");
      rmode = 0;
      out_ready = 1'b1;

      // Data FIFO underrun after byte 30 of 64.
      nsop = 0; neop = 0;
      push_pkt(64, 0, 0, 1, 9);
      for (int i = 0; i < 34; i++) held.push_front(dq.pop_back());
      refresh();
      begin
         int n;
         n = 0;
         while (dq.size() != 0 && n < 200) begin tick(); n++; end
         check("gap_drain_in_budget", int'(n < 200), 1);
      end
      repeat (10) tick();
      check("gap_busy", int'(busy), 1);
      check("gap_out_pending", expq.size(), 34);
      check("gap_ok_unchanged", int'(pkt_ok_cnt), exp_ok);
      while (held.size() > 0) dq.push_back(held.pop_front());
      refresh();
      wait_done("gap");
      exp_ok = sat(exp_ok);
      check("gap_ok_cnt", int'(pkt_ok_cnt), exp_ok);
      check("gap_sop_once", nsop, 1);
      check("gap_eop_once", neop, 1);

      // Reset during byte 20 of a forward.
      begin
         int a0, n;
         a0 = naccept; n = 0;
         push_pkt(64, 0, 0, 1, 33);
         refresh();
         while (naccept - a0 < 20 && n < 200) begin tick(); n++; end
         check("rst_mid_reach", int'(n < 200), 1);
      end
      reset = 1'b1;
      #1;
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_data", int'(out_data), 0);
      check("rst_mid_sop_eop", int'({out_sop, out_eop}), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_rd", int'({cmd_fifo_rd, data_fifo_rd}), 0);
      check("rst_mid_counts", int'({pkt_ok_cnt, pkt_drop_cnt}), 0);
      cq.delete(); dq.delete(); expq.delete();
      hold_pend = 1'b0;
      refresh();
      repeat (3) tick();
      reset = 1'b0;
      exp_ok = 0; exp_drop = 0;
      run_vec('{len: 60, crc: 0, del: 0, fwd: 1}, 71, "post_rst");

      // Drop counter saturation (narrow counters).
      for (int i = 0; i < CMAX + 5; i++) run_vec('{len: 0, crc: 0, del: 0, fwd: 0}, 0, "sat");
      check("sat_drop_cnt", int'(pkt_drop_cnt), CMAX);
      check("sat_ok_cnt", int'(pkt_ok_cnt), 1);

      check("rd_while_empty", viol_rd, 0);
      check("rd_while_stalled", viol_bp, 0);
      check("hold_stable", viol_hold, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
